// File: rtl/control_path_gen.sv
// Control-path generator: sequences s/y datapath command strobes for the
// ELIST countdown, the CNT incrementer and the fixed UPDATE sequence.
//
// Handshake: there is no valid/ready pair here; commands are one-cycle
// strobes that the datapath must act on in the cycle they are high.
//
// All outputs are registered. The next-state logic also works out the
// command for the upcoming cycle, and one register stage drives the ports.
module control_path_gen #(
    parameter int S_W         = 4,
    parameter int ELIST_START = 6,
    parameter int ELIST_STEP  = 2,
    parameter int HOLD        = 4,
    parameter int CNT_DIV     = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     on,
    input  logic           start,
    input  logic           y_inc,
    input  logic           abort,
    output logic [1:0]     regime,
    output logic           active,
    output logic           done,
    output logic           s_en,
    output logic           s_zero,
    output logic           s_add,
    output logic [S_W-1:0] s_step,
    output logic           y_en,
    output logic           y_store_x,
    output logic [1:0]     y_select_next,
    output logic [3:0]     dbg_state
);

    typedef enum logic [3:0] {
        ST_OFF, ST_EL_WAIT, ST_EL_LOAD, ST_EL_HOLD, ST_EL_DEC, ST_EL_END,
        ST_CNT, ST_UP1, ST_UP2, ST_UP3
    } state_t;

    // Number of decrements in one countdown; s itself is never read back.
    localparam int N_DEC = ELIST_START / ELIST_STEP;
    localparam int DW    = $clog2(N_DEC + 1);
    localparam int HW    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int CW    = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CNT_DIV - 1);

    state_t          state, nxt_state;
    logic [HW-1:0]   hold_cnt, nxt_hold;
    logic [DW-1:0]   dec_left, nxt_dec;
    logic [CW-1:0]   div_cnt, nxt_div;
    logic            inc_nxt, yinc_nxt;

    logic [1:0]      nxt_regime;
    logic            nxt_active, nxt_done, nxt_s_en, nxt_s_zero, nxt_s_add;
    logic [S_W-1:0]  nxt_s_step;
    logic            nxt_y_en, nxt_y_store_x;
    logic [1:0]      nxt_y_select;

    assign dbg_state = state;

    // Next state and counter updates; abort outranks every sequence step.
    always_comb begin
        nxt_state = state;
        nxt_hold  = hold_cnt;
        nxt_dec   = dec_left;
        nxt_div   = div_cnt;
        inc_nxt   = 1'b0;
        yinc_nxt  = 1'b0;
        if (state != ST_OFF && abort) begin
            nxt_state = ST_OFF;
            nxt_hold  = '0;
            nxt_dec   = '0;
            nxt_div   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    nxt_div = '0;
                    case (on)
                        2'd1:    nxt_state = ST_EL_WAIT;
                        2'd2:    nxt_state = ST_CNT;
                        2'd3:    nxt_state = ST_UP1;
                        default: nxt_state = ST_OFF;
                    endcase
                end
                ST_EL_WAIT: if (start) nxt_state = ST_EL_LOAD;
                ST_EL_LOAD: begin
                    nxt_dec   = DW'(N_DEC);
                    nxt_hold  = '0;
                    nxt_state = ST_EL_HOLD;
                end
                ST_EL_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        nxt_hold  = '0;
                        nxt_state = (dec_left != '0) ? ST_EL_DEC : ST_EL_END;
                    end else begin
                        nxt_hold = hold_cnt + HW'(1);
                    end
                end
                ST_EL_DEC: begin
                    nxt_dec   = dec_left - DW'(1);
                    nxt_state = ST_EL_HOLD;
                end
                ST_EL_END: nxt_state = ST_OFF;
                ST_CNT: begin
                    if (!start) begin
                        nxt_state = ST_OFF;
                        nxt_div   = '0;
                    end else begin
                        if (div_cnt == '0) begin
                            inc_nxt  = 1'b1;
                            yinc_nxt = y_inc;
                        end
                        nxt_div = (div_cnt == DIV_LAST) ? '0 : div_cnt + CW'(1);
                    end
                end
                ST_UP1:  nxt_state = ST_UP2;
                ST_UP2:  nxt_state = ST_UP3;
                ST_UP3:  nxt_state = ST_OFF;
                default: nxt_state = ST_OFF;
            endcase
        end
    end

    // Command decode for the cycle the FSM is about to enter.
    always_comb begin
        nxt_regime    = 2'd0;
        nxt_active    = 1'b0;
        nxt_done      = 1'b0;
        nxt_s_en      = 1'b0;
        nxt_s_zero    = 1'b0;
        nxt_s_add     = 1'b0;
        nxt_s_step    = '0;
        nxt_y_en      = 1'b0;
        nxt_y_store_x = 1'b0;
        nxt_y_select  = 2'd0;
        case (nxt_state)
            ST_EL_WAIT: nxt_regime = 2'd1;
            ST_EL_LOAD: begin
                nxt_regime = 2'd1;
                nxt_active = 1'b1;
                nxt_s_en   = 1'b1;
                nxt_s_zero = 1'b1;
                nxt_s_add  = 1'b1;
                nxt_s_step = S_W'(ELIST_START);
            end
            ST_EL_HOLD: begin
                nxt_regime = 2'd1;
                nxt_active = 1'b1;
            end
            ST_EL_DEC: begin
                nxt_regime = 2'd1;
                nxt_active = 1'b1;
                nxt_s_en   = 1'b1;
                nxt_s_step = S_W'(ELIST_STEP);
            end
            ST_EL_END: begin
                nxt_regime = 2'd1;
                nxt_done   = 1'b1;
                nxt_s_en   = 1'b1;
                nxt_s_zero = 1'b1;
                nxt_s_add  = 1'b1;
                nxt_s_step = S_W'(ELIST_START);
            end
            ST_CNT: begin
                nxt_regime = 2'd2;
                if (inc_nxt) begin
                    nxt_s_en   = 1'b1;
                    nxt_s_add  = 1'b1;
                    nxt_s_step = S_W'(1);
                end
                if (yinc_nxt) begin
                    nxt_y_en     = 1'b1;
                    nxt_y_select = 2'd1;
                end
            end
            ST_UP1: begin
                nxt_regime    = 2'd3;
                nxt_y_en      = 1'b1;
                nxt_y_store_x = 1'b1;
            end
            ST_UP2: begin
                nxt_regime   = 2'd3;
                nxt_y_en     = 1'b1;
                nxt_y_select = 2'd2;
            end
            ST_UP3: begin
                nxt_regime = 2'd3;
                nxt_s_en   = 1'b1;
                nxt_s_step = S_W'(1);
                nxt_done   = 1'b1;
            end
            default: nxt_regime = 2'd0;
        endcase
    end

    // State, counters and output registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_OFF;
            hold_cnt      <= '0;
            dec_left      <= '0;
            div_cnt       <= '0;
            regime        <= 2'd0;
            active        <= 1'b0;
            done          <= 1'b0;
            s_en          <= 1'b0;
            s_zero        <= 1'b0;
            s_add         <= 1'b0;
            s_step        <= '0;
            y_en          <= 1'b0;
            y_store_x     <= 1'b0;
            y_select_next <= 2'd0;
        end else begin
            state         <= nxt_state;
            hold_cnt      <= nxt_hold;
            dec_left      <= nxt_dec;
            div_cnt       <= nxt_div;
            regime        <= nxt_regime;
            active        <= nxt_active;
            done          <= nxt_done;
            s_en          <= nxt_s_en;
            s_zero        <= nxt_s_zero;
            s_add         <= nxt_s_add;
            s_step        <= nxt_s_step;
            y_en          <= nxt_y_en;
            y_store_x     <= nxt_y_store_x;
            y_select_next <= nxt_y_select;
        end
    end

endmodule
